// File: rtl/ksa.sv
// RC4 key-scheduling stage: runs the 256-iteration swap loop over the shared S memory.
// It starts when the init stage finishes and raises a sticky finish for the PRGA stage.
module ksa #(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_WIDTH-1:0]  secret_key,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  wren,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  finish
);

    localparam int KEY_BYTES = KEY_WIDTH / 8;
    localparam int KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0]         K_LAST = KW'(KEY_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] I_LAST = '1;

    typedef enum logic [2:0] {
        IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] i;
    logic [DATA_WIDTH-1:0] j;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] si;
    logic [DATA_WIDTH-1:0] sj;
    logic [7:0]            key_byte;
    logic [DATA_WIDTH-1:0] j_next;

    // Key byte 0 is the most significant byte of secret_key.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k == KW'(b)) key_byte = secret_key[KEY_WIDTH-1-8*b -: 8];
        end
    end

    assign j_next = j + q + DATA_WIDTH'(key_byte);

    // Outputs are registered and loaded on entry to the state that presents them.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;
            finish  <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            si      <= '0;
            sj      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    address <= '0;
                    data    <= '0;
                    wren    <= 1'b0;
                    if (start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= RD_I;
                    end
                end
                RD_I: begin
                    address <= i;
                    state   <= LAT_I;
                end
                LAT_I: begin
                    si      <= q;
                    j       <= j_next;
                    address <= j_next;
                    state   <= RD_J;
                end
                RD_J: begin
                    address <= j;
                    state   <= LAT_J;
                end
                LAT_J: begin
                    sj      <= q;
                    address <= i;
                    data    <= q;
                    wren    <= 1'b1;
                    state   <= WR_I;
                end
                WR_I: begin
                    address <= j;
                    data    <= si;
                    wren    <= 1'b1;
                    state   <= WR_J;
                end
                WR_J: begin
                    wren <= 1'b0;
                    if (i == I_LAST) begin
                        address <= '0;
                        data    <= '0;
                        finish  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        i       <= i + 1'b1;
                        k       <= (k == K_LAST) ? '0 : k + 1'b1;
                        address <= i + 1'b1;
                        state   <= RD_I;
                    end
                end
                DONE: begin
                    wren   <= 1'b0;
                    finish <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: team-style RAM model, directed vectors and a software RC4 KSA reference.
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] secret_key;
    logic        start;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [7:0]  q;
    logic        finish;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] addr_q;
    logic [7:0] exp_s [256];
    int         wr_addr [$];
    int         wr_data [$];
    int         ref_addr [$];
    int         ref_data [$];

    always #5 clk = ~clk;

    ksa dut (
        .clk        (clk),
        .rst        (rst),
        .secret_key (secret_key),
        .start      (start),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .q          (q),
        .finish     (finish)
    );

    // Registered address, unregistered q, old data on read-during-write.
    always @(posedge clk) begin
        if (wren) mem[address] <= data;
        addr_q <= address;
    end
    assign q = mem[addr_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic init_mem();
        for (int n = 0; n < 256; n++) mem[n] = 8'(n);
    endtask

    task automatic build_model(input logic [23:0] key);
        logic [7:0] jj;
        logic [7:0] t;
        logic [7:0] kb;
        jj = 0;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            kb = key[23 - 8*(n % 3) -: 8];
            jj = jj + exp_s[n] + kb;
            t = exp_s[n];
            exp_s[n] = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; cycles counts edges after the start-sampling edge.
    task automatic run_ksa(input logic [23:0] key, input bit hold, output int cycles);
        wr_addr.delete();
        wr_data.delete();
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        cycles = 0;
        while (cycles < 2000) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (finish) break;
            if (wren) begin
                wr_addr.push_back(int'(address));
                wr_data.push_back(int'(data));
            end
            @(posedge clk);
            cycles++;
        end
    endtask

    task automatic check_first_writes(input string tag, input int ea [6], input int ed [6]);
        for (int n = 0; n < 6; n++) begin
            if (wr_addr.size() > n) begin
                check($sformatf("%s_addr%0d", tag, n), wr_addr[n], ea[n]);
                check($sformatf("%s_data%0d", tag, n), wr_data[n], ed[n]);
            end else begin
                check($sformatf("%s_missing%0d", tag, n), 0, 1);
            end
        end
    endtask

    task automatic check_final_s(input string tag);
        for (int n = 0; n < 256; n++) check($sformatf("%s_S%0d", tag, n), mem[n], exp_s[n]);
    endtask

    task automatic compare_logs(input string tag);
        int bad;
        bad = 0;
        if (wr_addr.size() != ref_addr.size()) bad++;
        else
            for (int n = 0; n < wr_addr.size(); n++)
                if (wr_addr[n] != ref_addr[n] || wr_data[n] != ref_data[n]) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        int cyc;
        int bad;
        int wcount;
        int guard;
        logic [7:0] last_addr;
        int ea0 [6] = '{0, 0, 1, 1, 2, 3};
        int ed0 [6] = '{0, 0, 1, 1, 3, 2};
        int ea1 [6] = '{0, 0, 1, 4, 2, 8'h42};
        int ed1 [6] = '{0, 0, 4, 1, 8'h42, 2};

        rst = 1'b0;
        start = 1'b0;
        secret_key = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_address", address, 0);
        check("rst_data", data, 0);
        check("rst_wren", wren, 0);
        check("rst_finish", finish, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low: no memory activity.
        init_mem();
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (wren || address != 0 || finish) bad++;
        end
        check("idle_quiet", bad, 0);

        // Key 0x000000.
        run_ksa(24'h000000, 1'b0, cyc);
        check_first_writes("key0", ea0, ed0);
        check("key0_latency", cyc, 1536);
        build_model(24'h000000);
        check_final_s("key0");

        // Key 0x00033C with one-cycle start pulse.
        do_reset();
        init_mem();
        run_ksa(24'h00033C, 1'b0, cyc);
        check_first_writes("key33c", ea1, ed1);
        check("key33c_latency", cyc, 1536);
        check("key33c_nwrites", wr_addr.size(), 512);
        build_model(24'h00033C);
        check_final_s("key33c");
        ref_addr = wr_addr;
        ref_data = wr_data;

        // Same key with start held high through completion and beyond.
        do_reset();
        init_mem();
        run_ksa(24'h00033C, 1'b1, cyc);
        check("held_latency", cyc, 1536);
        compare_logs("held_vs_pulse");
        bad = 0;
        last_addr = address;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wren || !finish || address != last_addr) bad++;
        end
        check("done_sticky", bad, 0);
        start = 1'b0;

        // Asynchronous reset during a WR_I cycle, then a clean rerun.
        do_reset();
        init_mem();
        secret_key = 24'h00033C;
        start = 1'b1;
        @(posedge clk);
        wcount = 0;
        guard = 0;
        while (guard < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (wren) begin
                if (wcount == 40) break;
                wcount++;
            end
            guard++;
        end
        check("reach_wr_i", wren, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_wren", wren, 0);
        check("midrst_address", address, 0);
        check("midrst_data", data, 0);
        check("midrst_finish", finish, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_mem();
        run_ksa(24'h00033C, 1'b0, cyc);
        check("rerun_latency", cyc, 1536);
        compare_logs("rerun_writes");
        check_final_s("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
